// File: rtl/alu_mul_seq_if.sv
// Bus between the multiply sequencer and its surroundings: the request/result
// side (start, operands, busy/done, hi/lo) and the borrowed-ALU side
// (operands, control, ownership flag and the combinational result).
//
//   start, src_a, src_b   request and operands, captured when accepted
//   busy, done            status; done is a one-cycle completion pulse
//   hi, lo                64-bit product registers
//   alu_own               steers the datapath ALU input mux to the sequencer
//   alu_a, alu_b          ALU operands
//   alu_cont              ALU control
//   alu_result            combinational result from the shared ALU
//
// The slave modport is the sequencer; the master modport is the datapath/core.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             alu_own;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cont;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start, src_a, src_b, alu_result,
    output busy, done, hi, lo, alu_own, alu_a, alu_b, alu_cont
  );

  modport master (
    output start, src_a, src_b, alu_result,
    input  busy, done, hi, lo, alu_own, alu_a, alu_b, alu_cont
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Multicycle unsigned 32x32 -> 64 multiplier (MULTU) that borrows the core's
// combinational ALU as its adder. Radix-2 shift-add, one ALU add per cycle for
// 32 cycles; the product is left in hi/lo.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    alu_mul_seq_if.slave (request/result and borrowed-ALU signals)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; hi/lo hold the last product
// RUN    | owns the ALU; one add + shift per cycle, 32 cycles
// DONE   | one-cycle done pulse; hi/lo final; returns to IDLE next edge
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_mul_seq_if.slave bus
);

  localparam logic [2:0]       ALU_ADD  = 3'b010;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] sum;
  logic             carry;

  logic             alu_own;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_cont;

  // The ALU is 32 bits wide and has no carry-out we can see, so the carry of
  // hi + addend is recovered locally: an unsigned add wrapped iff sum < hi.
  assign sum   = bus.alu_result;
  assign carry = (sum < hi);

  always_comb begin
    state_nxt = state;
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cont  = 3'b000;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_RUN;
      end
      S_RUN: begin
        alu_own  = 1'b1;
        alu_a    = hi;
        alu_b    = lo[0] ? mcand : '0;
        alu_cont = ALU_ADD;
        if (cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mcand <= bus.src_a;
            lo    <= bus.src_b;
            hi    <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          // {hi,lo} shifts right by one with the new partial sum entering hi;
          // the multiplier bit just consumed drops out of lo[0]. The counter
          // wraps to 0 after the last iteration, which is never observed.
          hi  <= {carry, sum[WIDTH-1:1]};
          lo  <= {sum[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.hi       = hi;
  assign bus.lo       = lo;
  assign bus.alu_own  = alu_own;
  assign bus.alu_a    = alu_a;
  assign bus.alu_b    = alu_b;
  assign bus.alu_cont = alu_cont;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  logic clk;
  logic reset;

  alu_mul_seq_if #(.WIDTH(32)) bus ();

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: single-cycle combinational, add on control 010.
  always_comb begin
    bus.alu_result = (bus.alu_cont == 3'b010) ? (bus.alu_a + bus.alu_b) : 32'h0;
  end

  typedef struct {
    logic [63:0] prod;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  int          own_run = 0;
  bit          after_done = 0;
  logic [63:0] last_prod = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (after_done) begin
      check_val("hold_hilo", {bus.hi, bus.lo}, last_prod);
      check_val("idle_after_done", 64'(bus.busy), 64'd0);
      after_done = 0;
    end
    if (reset) own_run = 0;
    else if (bus.alu_own) begin
      own_run++;
      check_val("alu_cont_run", 64'(bus.alu_cont), 64'h2);
    end
    if (bus.done) begin
      if (sb.size() == 0) check_val("spurious_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check_val("hi", 64'(bus.hi), 64'(e.prod[63:32]));
        check_val("lo", 64'(bus.lo), 64'(e.prod[31:0]));
        check_val("latency", 64'(edge_cnt - e.acc), 64'd32);
        check_val("own_cycles", 64'(own_run), 64'd32);
        check_val("busy_in_done", 64'(bus.busy), 64'd1);
        check_val("own_in_done", 64'(bus.alu_own), 64'd0);
        last_prod  = e.prod;
        after_done = 1;
      end
      own_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; acceptance happens at the next edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.start = 1'b1;
    bus.src_a = a;
    bus.src_b = b;
    e.prod = 64'(a) * 64'(b);
    e.acc  = edge_cnt + 1;
    sb.push_back(e);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      check_val("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    tick();
    tick();
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check_val("rst_own", 64'(bus.alu_own), 64'd0);
    check_val("rst_alu", {bus.alu_a, bus.alu_b}, 64'd0);
    check_val("rst_cont", 64'(bus.alu_cont), 64'd0);
    reset = 1'b0;
    tick();

    // Basic, carry path, zero and identity.
    do_op(32'd3, 32'd5);                 wait_done(40);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF);   wait_done(40);
    do_op(32'h80000000, 32'd2);          wait_done(40);
    do_op(32'd0, 32'h12345678);          wait_done(40);
    do_op(32'hDEADBEEF, 32'd1);          wait_done(40);
    for (int i = 0; i < 3; i++) begin
      do_op($urandom, $urandom);
      wait_done(40);
    end

    // Busy rejection and operand isolation.
    do_op(32'd3, 32'd5);
    repeat (9) tick();
    bus.start = 1'b1;
    bus.src_a = 32'd7;
    bus.src_b = 32'd7;
    tick();
    bus.start = 1'b0;
    bus.src_a = 32'd99;
    bus.src_b = 32'd1234;
    repeat (22) tick();
    bus.start = 1'b1;                     // during DONE: must be ignored
    tick();
    bus.start = 1'b0;
    wait_done(5);
    repeat (40) tick();                   // any second done is spurious

    // Reset mid-operation aborts without a done.
    do_op(32'hFFFF, 32'hFFFF);
    repeat (11) tick();
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check_val("abort_own", 64'(bus.alu_own), 64'd0);
    repeat (40) tick();
    do_op(32'd6, 32'd7);                 wait_done(40);

    // Back-to-back with start held high: second accept 34 edges later.
    bus.start = 1'b1;
    bus.src_a = 32'd2;
    bus.src_b = 32'd3;
    e.prod = 64'd6;
    e.acc  = edge_cnt + 1;
    sb.push_back(e);
    tick();
    bus.src_a = 32'd4;
    bus.src_b = 32'd5;
    e.prod = 64'd20;
    e.acc  = edge_cnt + 34;
    sb.push_back(e);
    repeat (34) tick();
    bus.start = 1'b0;
    wait_done(40);
    tick();

    // Reset wins over a simultaneous start.
    reset     = 1'b1;
    bus.start = 1'b1;
    tick();
    check_val("rst_start_busy", 64'(bus.busy), 64'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    check_val("rst_start_idle", 64'(bus.busy), 64'd0);
    repeat (3) tick();

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
